seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of time-multiplexed digits (range 2..8).
REQ-002 SHALL have parameter DIV, default 50000: clock cycles per digit slot.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16: ghosting-guard cycles at the start of each slot; 1 <= BLANK_CYCLES < DIV.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, in this port order:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 is least significant.
- dp  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- load  in  1  single-cycle strobe that offers value/dp for display.
- ack  out  1  one-cycle pulse when a loaded value reaches the display buffer.
- leds  out  8  active-low segments; bit7 = DP, bits6..0 = g..a.
- an  out  NUM_DIGITS  active-low digit enables.
- frame_start  out  1  one-cycle pulse at the start of each digit-0 slot.

Function
REQ-005 SHALL keep a free-running slot counter cnt in 0..DIV-1 and a digit index idx in 0..NUM_DIGITS-1; idx advances when cnt wraps, and wraps from NUM_DIGITS-1 to 0.
REQ-006 SHALL use two states, BLANK (cnt < BLANK_CYCLES) and SHOW (cnt >= BLANK_CYCLES).
- BLANK -> SHOW when cnt = BLANK_CYCLES-1.
- SHOW -> BLANK on cnt wrap.
REQ-007 In BLANK, SHALL drive an all 1s and leds 8'hFF.
REQ-008 In SHOW, SHALL drive an = ~(1<<idx), and leds[6:0] from display-buffer nibble idx.
REQ-009 Segment codes in hex for nibbles 0..F SHALL be: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (bit7 shown as 1).
REQ-010 In SHOW, leds[7] SHALL equal ~dp_buf[idx].
REQ-011 leds, an and frame_start SHALL be registered outputs, valid one cycle after the cnt/idx state that selects them.
REQ-012 load SHALL capture value/dp into a pending buffer and set pending_valid.
- A load while pending_valid is set overwrites the pending buffer; the latest value wins.
REQ-013 The commit cycle SHALL be the cycle with idx = 0 and cnt = 0. On it:
- if load is asserted, the load inputs are copied directly to the display buffer;
- otherwise, if pending_valid is set, the pending buffer is copied;
- pending_valid is cleared in both cases.
REQ-014 ack SHALL pulse high for exactly one cycle, in the cycle after each commit that copied data.
- Multiple loads coalesced into one commit produce one ack.
REQ-015 frame_start SHALL pulse high for one cycle aligned with the first BLANK output cycle of digit 0.
REQ-016 Display content SHALL never change mid-frame; a commit happens only at the frame boundary.
REQ-017 Frame period SHALL be exactly NUM_DIGITS*DIV cycles.

Reset
REQ-018 On reset assertion, SHALL asynchronously set:
- cnt = 0, idx = 0, state BLANK;
- display buffer and dp_buf = 0, pending_valid = 0;
- an all 1s, leds = 8'hFF, ack = 0, frame_start = 0.
REQ-019 Reset mid-frame SHALL discard any pending load and produce no ack.
REQ-020 After reset release, the first SHOW shall display digit 0 = C0.

Configuration
REQ-021 Macro SEG7_LZB_EN SHALL control leading-zero blanking.
- Defined: any digit i > 0 whose nibble and all higher nibbles are 0, and whose dp_buf bit is 0, keeps an and leds at all 1s during SHOW. Digit 0 is never blanked.
- Not defined: all digits are always displayed.

Verification
(Bench parameters for all scenarios: NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2.)
REQ-022 Reset, then run 32 cycles -> an = 1110, 1101, 1011, 0111, each low for 6 cycles after 2 blank cycles; frame_start once per 32 cycles.
REQ-023 load value=16'h12AF, dp=4'b0100 mid-frame -> nothing changes until the frame boundary; ack 1 cycle after commit; digit0 leds 8E, digit1 A1... wait, digit1 = nibble A -> 88, digit2 = 2 with DP -> 24, digit3 = 1 -> F9.
REQ-024 Two loads, 16'h1111 then 16'h2222, in the same frame -> one ack; all digits show A4.
REQ-025 load asserted exactly on the commit cycle with value 16'h0009 -> digit0 = 90 in the same frame; with SEG7_LZB_EN digits 1..3 are blank, without it they show C0.
REQ-026 Reset asserted at idx=2 while a load is pending -> outputs go to FF / all-1s immediately; no ack; display = 0000.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed 7-segment display scanner. It steps through
//                NUM_DIGITS digits, giving each one a slot of DIV cycles. Each
//                slot opens with BLANK_CYCLES of all-off output to suppress
//                ghosting. New content is double-buffered: a load goes to a
//                pending buffer, which is committed only at the frame boundary.
//                Optional feature: define SEG7_LZB_EN to enable leading-zero
//                blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic                      load,
    output logic                      ack,
    output logic [7:0]                leds,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_start
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Nibble to active-low segment pattern, bits 6..0 = g..a
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

    // Scan position
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    state_t                  state_q, state_d;

    // Pending and display buffers
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   dpbuf_q, dpbuf_d;

    // Registered outputs
    logic                    ack_q, ack_d;
    logic [7:0]              leds_q, leds_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fs_q, fs_d;

    // Combinational helpers
    logic                    w_cnt_wrap;
    logic                    w_frame_edge;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_lz_sel;

    // Slot counter and digit index advance; frame edge is idx 0 / cnt 0
    always_comb begin
        w_cnt_wrap   = (cnt_q == CNT_LAST);
        w_frame_edge = (cnt_q == '0) && (idx_q == '0);
        cnt_d        = w_cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        if (w_cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // BLANK/SHOW next-state logic, tracking the slot counter
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
            ST_SHOW:  if (w_cnt_wrap)          state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase
    end

    // Load capture into pending buffer and commit into display buffer at frame edge
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        dpbuf_d      = dpbuf_q;
        ack_d        = 1'b0;
        if (w_frame_edge) begin
            // A load on the commit cycle bypasses the pending buffer entirely
            pend_valid_d = 1'b0;
            if (load) begin
                disp_d  = value;
                dpbuf_d = dp;
                ack_d   = 1'b1;
            end else if (pend_valid_q) begin
                disp_d  = pend_val_q;
                dpbuf_d = pend_dp_q;
                ack_d   = 1'b1;
            end
        end else if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp;
            pend_valid_d = 1'b1;
        end
    end

`ifdef SEG7_LZB_EN
    logic w_zero_run;

    // Digit i>0 is blanked when it and every higher nibble is zero and its DP is off
    always_comb begin
        w_lz       = '0;
        w_zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run && (disp_q[4*i +: 4] == 4'h0);
            w_lz[i]    = w_zero_run && !dpbuf_q[i];
        end
    end
`else
    assign w_lz = '0;
`endif

    // Select the current digit's data and form the next output pattern
    always_comb begin
        w_nib    = 4'h0;
        w_dp_sel = 1'b0;
        w_lz_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_nib    = disp_q[4*i +: 4];
                w_dp_sel = dpbuf_q[i];
                w_lz_sel = w_lz[i];
            end
        end
        an_d   = '1;
        leds_d = 8'hFF;
        if ((state_q == ST_SHOW) && !w_lz_sel) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_q != IDX_W'(i));
            end
            leds_d = {~w_dp_sel, seg_decode(w_nib)};
        end
        fs_d = w_frame_edge;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_q       <= '0;
            dpbuf_q      <= '0;
            ack_q        <= 1'b0;
            leds_q       <= 8'hFF;
            an_q         <= '1;
            fs_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
            dpbuf_q      <= dpbuf_d;
            ack_q        <= ack_d;
            leds_q       <= leds_d;
            an_q         <= an_d;
            fs_q         <= fs_d;
        end
    end

    assign ack         = ack_q;
    assign leds        = leds_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, DIV=8,
//                BLANK_CYCLES=2). Table of load vectors with hand-computed
//                per-digit segment codes; every output cycle of every frame
//                is compared. Honours SEG7_LZB_EN for the blanking masks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        ack;
    logic [7:0]  leds;
    logic [3:0]  an;
    logic        frame_start;

    int n_vec = 0;
    int n_err = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DIV          (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .dp          (dp),
        .load        (load),
        .ack         (ack),
        .leds        (leds),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v1;
        logic [3:0]  p1;
        int          at1;       // frame cycle after which load is driven
        logic [15:0] v2;
        logic [3:0]  p2;
        int          at2;       // 0 = no second load
        logic [31:0] exp_leds;  // {digit3, digit2, digit1, digit0}
        logic [3:0]  lzb_mask;  // digits blanked when leading-zero blanking is on
    } vec_t;

    vec_t vecs[8];

    // Run nt cycles of a frame, checking all outputs each cycle, and drive loads
    task automatic run_frame(input string tag, input logic [31:0] el, input logic [3:0] bm,
                             input logic ea, input int nt,
                             input logic [15:0] v1, input logic [3:0] p1, input int a1,
                             input logic [15:0] v2, input logic [3:0] p2, input int a2);
        int s, c, d;
        logic       blank;
        logic [3:0] m;
        logic [3:0] e_an;
        logic [7:0] e_leds;
        logic       e_fs, e_ack;
`ifdef SEG7_LZB_EN
        m = bm;
`else
        m = 4'b0000;
`endif
        for (int j = 1; j <= nt; j++) begin
            @(posedge clk); #1;
            s      = j - 1;
            c      = s % 8;
            d      = s / 8;
            blank  = (c < 2) || m[d];
            e_an   = blank ? 4'hF : ~(4'b0001 << d);
            e_leds = blank ? 8'hFF : el[8*d +: 8];
            e_fs   = (j == 1);
            e_ack  = (j == 1) && ea;
            n_vec++;
            if ({ack, frame_start, an, leds} !== {e_ack, e_fs, e_an, e_leds}) begin
                n_err++;
                $display("FAIL %s cycle %0d: ack/fs/an/leds got %b/%b/%b/%h, required %b/%b/%b/%h",
                         tag, j, ack, frame_start, an, leds, e_ack, e_fs, e_an, e_leds);
            end
            load = 1'b0;
            if (j == a1) begin
                load = 1'b1; value = v1; dp = p1;
            end else if ((a2 != 0) && (j == a2)) begin
                load = 1'b1; value = v2; dp = p2;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if ({ack, frame_start, an, leds} !== {1'b0, 1'b0, 4'hF, 8'hFF}) begin
            n_err++;
            $display("FAIL %s: ack/fs/an/leds got %b/%b/%b/%h, required 0/0/1111/ff",
                     tag, ack, frame_start, an, leds);
        end
    endtask

    logic [31:0] cur_leds;
    logic [3:0]  cur_mask;
    logic        pend_ack;

    initial begin
        vecs[0] = '{16'h12AF, 4'b0100, 12, 16'h0000, 4'b0000, 0,  32'hF924888E, 4'b0000};
        vecs[1] = '{16'h1111, 4'b0000, 5,  16'h2222, 4'b0000, 20, 32'hA4A4A4A4, 4'b0000};
        vecs[2] = '{16'h0009, 4'b0000, 32, 16'h0000, 4'b0000, 0,  32'hC0C0C090, 4'b1110};
        vecs[3] = '{16'h0000, 4'b1010, 31, 16'h0000, 4'b0000, 0,  32'h40C040C0, 4'b0100};
        vecs[4] = '{16'h00F0, 4'b0000, 1,  16'h0000, 4'b0000, 0,  32'hC0C08EC0, 4'b1100};
        vecs[5] = '{16'hBCDE, 4'b1111, 16, 16'h0000, 4'b0000, 0,  32'h03462106, 4'b0000};
        vecs[6] = '{16'h3456, 4'b0000, 9,  16'h0000, 4'b0000, 0,  32'hB0999282, 4'b0000};
        vecs[7] = '{16'h7800, 4'b0000, 28, 16'h0000, 4'b0000, 0,  32'hF880C0C0, 4'b0000};

        reset = 1'b1;
        value = 16'h0000;
        dp    = 4'b0000;
        load  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset = 1'b0;

        // Idle scan after reset: zero display, no ack
        cur_leds = 32'hC0C0C0C0;
        cur_mask = 4'b1110;
        run_frame("idle_scan", cur_leds, cur_mask, 1'b0, 32,
                  16'h0, 4'h0, 0, 16'h0, 4'h0, 0);

        // Table vectors: loads in one frame show up (with one ack) in the next
        pend_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("vec%0d_load", i), cur_leds, cur_mask, pend_ack, 32,
                      vecs[i].v1, vecs[i].p1, vecs[i].at1,
                      vecs[i].v2, vecs[i].p2, vecs[i].at2);
            cur_leds = vecs[i].exp_leds;
            cur_mask = vecs[i].lzb_mask;
            pend_ack = 1'b1;
        end
        run_frame("last_commit", cur_leds, cur_mask, 1'b1, 32,
                  16'h0, 4'h0, 0, 16'h0, 4'h0, 0);
        run_frame("hold_no_ack", cur_leds, cur_mask, 1'b0, 32,
                  16'h0, 4'h0, 0, 16'h0, 4'h0, 0);

        // Reset in digit-2 slot with a load pending
        run_frame("pre_reset", cur_leds, cur_mask, 1'b0, 20,
                  16'h8888, 4'b1111, 5, 16'h0, 4'h0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk); #1;
        check_reset_outputs("reset_held");
        reset = 1'b0;
        run_frame("post_reset", 32'hC0C0C0C0, 4'b1110, 1'b0, 32,
                  16'h0, 4'h0, 0, 16'h0, 4'h0, 0);
        run_frame("pending_dropped", 32'hC0C0C0C0, 4'b1110, 1'b0, 32,
                  16'h0, 4'h0, 0, 16'h0, 4'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
